// File: rtl/cpu_defs.sv
// cpu_defs: shared definitions for the interrupt controller.
//   NUM_INT_DEF / ID_W_DEF : default line count and index width
//   irq_state_t            : controller FSM state encoding
package cpu_defs;

    localparam int NUM_INT_DEF = 6;
    localparam int ID_W_DEF    = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational fixed-priority encoder, highest index wins.
//   i_req   [NUM_INT-1:0] : candidate lines (already masked)
//   o_valid               : at least one candidate is set
//   o_id    [ID_W-1:0]    : index of the highest set candidate (0 if none)
module irq_prio_enc
    import cpu_defs::*;
#(
    parameter int NUM_INT = NUM_INT_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic [NUM_INT-1:0] i_req,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_id
);

    always_comb begin
        o_valid = |i_req;
        o_id    = '0;
        // Ascending scan: a later (higher) set bit overwrites a lower one.
        for (int i = 0; i < NUM_INT; i++) begin
            if (i_req[i]) begin
                o_id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: single-level interrupt controller (IDLE -> REQ -> SERVICE).
//   Clk, Reset       : clock, asynchronous active-low reset
//   HWInt            : raw interrupt lines, active-high
//   MaskWE/MaskWData : mask register write (bit set = line enabled)
//   IEWE/IEWData     : global enable write
//   IntAck           : pipeline took the request (M stage)
//   Eret             : handler returned
//   IntReq           : registered request, high exactly while in REQ
//   IntId            : index captured on entry to REQ, held through SERVICE
//   Pending          : pending register
//   InService        : high while a handler is active
// Build option: define IRQ_CTRL_EDGE_EN for sticky rising-edge pending
// capture; without it Pending follows HWInt every cycle (level mode).
module irq_ctrl
    import cpu_defs::*;
#(
    parameter int NUM_INT = NUM_INT_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_INT-1:0] HWInt,
    input  logic               MaskWE,
    input  logic [NUM_INT-1:0] MaskWData,
    input  logic               IEWE,
    input  logic               IEWData,
    input  logic               IntAck,
    input  logic               Eret,
    output logic               IntReq,
    output logic [ID_W-1:0]    IntId,
    output logic [NUM_INT-1:0] Pending,
    output logic               InService
);

    irq_state_t         r_state;
    irq_state_t         w_state_nxt;
    logic [NUM_INT-1:0] r_mask;
    logic               r_ie;
    logic [NUM_INT-1:0] r_pending;
    logic [ID_W-1:0]    r_id;

    logic [NUM_INT-1:0] w_mask_nxt;
    logic               w_ie_nxt;
    logic [NUM_INT-1:0] w_avail;
    logic [NUM_INT-1:0] w_pend_nxt;
    logic [NUM_INT-1:0] w_live;
    logic               w_valid;
    logic [ID_W-1:0]    w_win_id;

    // Decisions see this edge's register writes, so a write landing with
    // IntAck already governs whether the ack is honoured.
    assign w_mask_nxt = MaskWE ? MaskWData : r_mask;
    assign w_ie_nxt   = IEWE   ? IEWData   : r_ie;

`ifdef IRQ_CTRL_EDGE_EN
    logic [NUM_INT-1:0] r_hw_prev;
    logic [NUM_INT-1:0] w_rise;
    logic [NUM_INT-1:0] w_clr;
    logic               w_take;

    assign w_rise  = HWInt & ~r_hw_prev;
    assign w_avail = r_pending | w_rise;
    assign w_take  = (r_state == ST_REQ) && (w_state_nxt == ST_SERVICE);
    // A new edge on the acknowledged line wins over the clear.
    assign w_clr      = w_take ? (NUM_INT'(1) << r_id) : '0;
    assign w_pend_nxt = (r_pending & ~w_clr) | w_rise;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_hw_prev <= '0;
        end else begin
            r_hw_prev <= HWInt;
        end
    end
`else
    assign w_avail    = HWInt;
    assign w_pend_nxt = HWInt;
`endif

    assign w_live = w_avail & w_mask_nxt;

    irq_prio_enc #(
        .NUM_INT (NUM_INT),
        .ID_W    (ID_W)
    ) u_prio (
        .i_req   (w_live),
        .o_valid (w_valid),
        .o_id    (w_win_id)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ie_nxt && w_valid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // Losing the line or the enable withdraws the request even
                // if the ack arrives on the same edge.
                if (!w_ie_nxt || !w_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (IntAck) begin
                    w_state_nxt = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (Eret) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_mask    <= '1;
            r_ie      <= 1'b0;
            r_pending <= '0;
            r_id      <= '0;
        end else begin
            r_mask    <= w_mask_nxt;
            r_ie      <= w_ie_nxt;
            r_pending <= w_pend_nxt;
            if (r_state == ST_IDLE && w_state_nxt == ST_REQ) begin
                r_id <= w_win_id;
            end
        end
    end

    // Decodes of the state flop; no combinational path from inputs.
    assign IntReq    = (r_state == ST_REQ);
    assign InService = (r_state == ST_SERVICE);
    assign IntId     = r_id;
    assign Pending   = r_pending;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed bench for irq_ctrl (6-line instance checked every
// cycle against a behavioural model, plus an 8-line instance).
// Follows IRQ_CTRL_EDGE_EN the same way the design does.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       Clk;
    logic       Reset;
    logic [5:0] HWInt;
    logic       MaskWE;
    logic [5:0] MaskWData;
    logic       IEWE;
    logic       IEWData;
    logic       IntAck;
    logic       Eret;
    logic       IntReq;
    logic [2:0] IntId;
    logic [5:0] Pending;
    logic       InService;

    logic [7:0] HWInt8;
    logic       IEWE8;
    logic       IEWData8;
    logic       IntReq8;
    logic [2:0] IntId8;
    logic [7:0] Pending8;
    logic       InService8;

    int n_vec = 0;
    int n_err = 0;

    irq_ctrl #(.NUM_INT(6), .ID_W(3)) u_dut (
        .Clk(Clk), .Reset(Reset), .HWInt(HWInt),
        .MaskWE(MaskWE), .MaskWData(MaskWData),
        .IEWE(IEWE), .IEWData(IEWData),
        .IntAck(IntAck), .Eret(Eret),
        .IntReq(IntReq), .IntId(IntId), .Pending(Pending), .InService(InService)
    );

    irq_ctrl #(.NUM_INT(8), .ID_W(3)) u_dut8 (
        .Clk(Clk), .Reset(Reset), .HWInt(HWInt8),
        .MaskWE(1'b0), .MaskWData(8'h00),
        .IEWE(IEWE8), .IEWData(IEWData8),
        .IntAck(1'b0), .Eret(1'b0),
        .IntReq(IntReq8), .IntId(IntId8), .Pending(Pending8), .InService(InService8)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_SVC  = 2;

    int         m_phase;
    int         m_id;
    logic [5:0] m_mask;
    logic [5:0] m_pend;
    logic [5:0] m_prev;
    bit         m_ie;
    logic [5:0] m_rise;
    logic [5:0] m_live;

    function automatic int highest(input logic [5:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 6; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_phase = P_IDLE;
            m_id    = 0;
            m_mask  = 6'h3F;
            m_pend  = 6'h00;
            m_prev  = 6'h00;
            m_ie    = 1'b0;
        end else begin
            if (MaskWE) m_mask = MaskWData;
            if (IEWE)   m_ie   = IEWData;
            if (EDGE) begin
                m_rise = HWInt & ~m_prev;
                m_pend = m_pend | m_rise;
                m_prev = HWInt;
            end else begin
                m_rise = 6'h00;
                m_pend = HWInt;
            end
            m_live = m_pend & m_mask;
            if (m_phase == P_IDLE) begin
                if (m_ie && m_live != 0) begin
                    m_phase = P_REQ;
                    m_id    = highest(m_live);
                end
            end else if (m_phase == P_REQ) begin
                if (!m_ie || m_live == 0) begin
                    m_phase = P_IDLE;
                end else if (IntAck) begin
                    m_phase = P_SVC;
                    if (EDGE && !m_rise[m_id]) m_pend[m_id] = 1'b0;
                end
            end else begin
                if (Eret) m_phase = P_IDLE;
            end
        end
    end

    always @(negedge Clk) begin
        if (Reset === 1'b1) begin
            chk("model IntReq",    int'(IntReq),    int'(m_phase == P_REQ));
            chk("model InService", int'(InService), int'(m_phase == P_SVC));
            chk("model IntId",     int'(IntId),     m_id);
            chk("model Pending",   int'(Pending),   int'(m_pend));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [5:0] hw, input logic mwe, input logic [5:0] mwd,
                       input logic iewe, input logic iewd, input logic ack, input logic er);
        HWInt = hw; MaskWE = mwe; MaskWData = mwd;
        IEWE = iewe; IEWData = iewd; IntAck = ack; Eret = er;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        HWInt = '0; MaskWE = 1'b0; MaskWData = '0; IEWE = 1'b0; IEWData = 1'b0;
        IntAck = 1'b0; Eret = 1'b0;
        HWInt8 = '0; IEWE8 = 1'b0; IEWData8 = 1'b0;
        #3;
        chk("reset IntReq", int'(IntReq), 0);
        chk("reset IntId", int'(IntId), 0);
        chk("reset Pending", int'(Pending), 0);
        chk("reset InService", int'(InService), 0);
        #8 Reset = 1'b1;

        // enable, single line 2
        cyc(6'h00, 0, 6'h00, 1, 1, 0, 0);
        chk("ie only IntReq", int'(IntReq), 0);
        cyc(6'h04, 0, 6'h00, 0, 0, 0, 0);
        chk("line2 IntReq", int'(IntReq), 1);
        chk("line2 IntId", int'(IntId), 2);
        cyc(6'h04, 0, 6'h00, 0, 0, 1, 0);
        chk("line2 ack InService", int'(InService), 1);
        chk("line2 ack Pending", int'(Pending), EDGE ? 0 : 4);
        cyc(6'h00, 0, 6'h00, 0, 0, 0, 1);

        // lines 5 and 0: priority, ack, ignored ack, eret
        cyc(6'h21, 0, 6'h00, 0, 0, 0, 0);
        chk("prio IntId", int'(IntId), 5);
        cyc(6'h21, 0, 6'h00, 0, 0, 1, 0);
        chk("svc InService", int'(InService), 1);
        chk("svc IntReq", int'(IntReq), 0);
        cyc(6'h21, 0, 6'h00, 0, 0, 1, 0);
        chk("svc ack ignored", int'(InService), 1);
        chk("svc IntId held", int'(IntId), 5);
        cyc(6'h21, 0, 6'h00, 0, 0, 0, 1);
        chk("eret InService", int'(InService), 0);
        chk("eret IntReq", int'(IntReq), 0);
        cyc(6'h21, 0, 6'h00, 0, 0, 0, 0);
        chk("rereq IntReq", int'(IntReq), 1);
        chk("rereq IntId", int'(IntId), EDGE ? 0 : 5);
        cyc(6'h00, 0, 6'h00, 0, 0, 0, 0);
        chk("drop IntReq", int'(IntReq), EDGE ? 1 : 0);
        cyc(6'h00, 0, 6'h00, 0, 0, 1, 0);
        cyc(6'h00, 0, 6'h00, 0, 0, 0, 1);

        // mask gating and post-write decisions
        cyc(6'h00, 1, 6'h00, 0, 0, 0, 0);
        cyc(6'h3F, 0, 6'h00, 0, 0, 0, 0);
        chk("masked IntReq", int'(IntReq), 0);
        cyc(6'h3F, 0, 6'h00, 0, 0, 0, 0);
        chk("masked IntReq 2", int'(IntReq), 0);
        cyc(6'h3F, 1, 6'h08, 0, 0, 0, 0);
        chk("mask08 IntReq", int'(IntReq), 1);
        chk("mask08 IntId", int'(IntId), 3);
        cyc(6'h3F, 0, 6'h00, 1, 0, 1, 0);
        chk("ie0+ack IntReq", int'(IntReq), 0);
        chk("ie0+ack InService", int'(InService), 0);
        cyc(6'h3F, 0, 6'h00, 1, 1, 0, 0);
        chk("ie1 IntId", int'(IntId), 3);
        cyc(6'h3F, 1, 6'h3F, 0, 0, 1, 0);
        chk("mask+ack InService", int'(InService), 1);
        chk("mask+ack IntId", int'(IntId), 3);
        cyc(6'h3F, 0, 6'h00, 0, 0, 0, 1);
        chk("eret+pend IntReq", int'(IntReq), 0);
        chk("eret+pend InService", int'(InService), 0);
        cyc(6'h3F, 0, 6'h00, 0, 0, 0, 0);
        chk("next edge IntReq", int'(IntReq), 1);
        chk("next edge IntId", int'(IntId), 5);

        // asynchronous reset while requesting
        #2 Reset = 1'b0;
        #1;
        chk("async IntReq", int'(IntReq), 0);
        chk("async IntId", int'(IntId), 0);
        chk("async Pending", int'(Pending), 0);
        chk("async InService", int'(InService), 0);
        #3 Reset = 1'b1;

        // one-cycle pulse on line 1
        cyc(6'h00, 0, 6'h00, 1, 1, 0, 0);
        cyc(6'h02, 0, 6'h00, 0, 0, 0, 0);
        chk("pulse IntId", int'(IntId), 1);
        cyc(6'h00, 0, 6'h00, 0, 0, 0, 0);
        chk("pulse Pending", int'(Pending), EDGE ? 2 : 0);
        chk("pulse IntReq", int'(IntReq), EDGE ? 1 : 0);
        cyc(6'h00, 0, 6'h00, 0, 0, 0, 0);
        chk("pulse Pending 2", int'(Pending), EDGE ? 2 : 0);
        cyc(6'h00, 0, 6'h00, 0, 0, 1, 0);
        chk("pulse ack Pending", int'(Pending), 0);
        chk("pulse ack InService", int'(InService), EDGE ? 1 : 0);
        cyc(6'h00, 0, 6'h00, 0, 0, 0, 1);
        cyc(6'h02, 0, 6'h00, 0, 0, 0, 0);
        cyc(6'h00, 0, 6'h00, 0, 0, 0, 0);
        cyc(6'h02, 0, 6'h00, 0, 0, 1, 0);
        chk("edge@ack Pending", int'(Pending), 2);
        chk("edge@ack InService", int'(InService), EDGE ? 1 : 0);
        chk("edge@ack IntReq", int'(IntReq), EDGE ? 0 : 1);
        cyc(6'h00, 0, 6'h00, 0, 0, 0, 1);

        // 8-line instance
        IEWE8 = 1'b1; IEWData8 = 1'b1;
        @(posedge Clk); #1;
        IEWE8 = 1'b0; HWInt8 = 8'h80;
        @(posedge Clk); #1;
        chk("n8 IntReq", int'(IntReq8), 1);
        chk("n8 IntId", int'(IntId8), 7);
        chk("n8 Pending", int'(Pending8), 8'h80);
        HWInt8 = 8'h81;
        @(posedge Clk); #1;
        chk("n8 IntId held", int'(IntId8), 7);
        chk("n8 InService", int'(InService8), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_INT, default 6, giving the number of hardware interrupt lines (range 1..32).
REQ-002 SHALL have parameter ID_W, default 3, giving the width of the interrupt index; ID_W SHALL be at least clog2(NUM_INT).
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port HWInt, input, NUM_INT bits: raw interrupt lines, active-high.
REQ-006 SHALL have port MaskWE, input, 1 bit: write strobe for the mask register.
REQ-007 SHALL have port MaskWData, input, NUM_INT bits: new mask value; bit set means the line is enabled.
REQ-008 SHALL have port IEWE, input, 1 bit: write strobe for the global enable.
REQ-009 SHALL have port IEWData, input, 1 bit: new global enable value.
REQ-010 SHALL have port IntAck, input, 1 bit: the pipeline has taken the interrupt, asserted at M stage.
REQ-011 SHALL have port Eret, input, 1 bit: the handler has returned.
REQ-012 SHALL have port IntReq, output, 1 bit: registered interrupt request to the pipeline.
REQ-013 SHALL have port IntId, output, ID_W bits: index of the requested or in-service line.
REQ-014 SHALL have port Pending, output, NUM_INT bits: the pending register.
REQ-015 SHALL have port InService, output, 1 bit: high while a handler is active (EXL equivalent).

Function
REQ-016 SHALL run an FSM with states IDLE, REQ and SERVICE.
REQ-017 SHALL move IDLE->REQ on the first edge where IE=1 and |(Pending & Mask) is nonzero.
REQ-018 SHALL move REQ->SERVICE on IntAck, and REQ->IDLE if (Pending & Mask) becomes zero or IE is written to 0 before IntAck.
REQ-019 SHALL move SERVICE->IDLE on Eret; IntAck received in SERVICE SHALL be ignored.
REQ-020 SHALL make IntReq registered and equal to 1 exactly while in REQ, giving 1-cycle latency from a pending, enabled line to IntReq.
REQ-021 SHALL use fixed priority with the highest index winning; IntId SHALL be captured on entry to REQ and held constant through SERVICE.
REQ-022 SHALL let Pending follow HWInt each cycle in level mode (default); a line deasserting before IntAck SHALL drop the request.
REQ-023 SHALL give a write and an IntAck in the same cycle: the write takes effect that edge and the FSM decision SHALL use post-write Mask/IE.
REQ-024 SHALL handle Eret and a new enabled pending line in the same cycle by going SERVICE->IDLE, then to REQ on the next edge; no cycle is skipped.
REQ-025 SHALL never assert IntReq while InService=1; nesting is not supported.

Reset
REQ-026 SHALL, on Reset low, asynchronously force state IDLE, IntReq=0, IntId=0, Pending=0, InService=0, Mask=all ones and IE=0.
REQ-027 SHALL, on Reset asserted mid-REQ or mid-SERVICE, abandon the request with no residual ack required; Reset released SHALL resume on the next rising Clk.

Configuration
REQ-028 SHALL, when macro IRQ_CTRL_EDGE_EN is defined, set Pending bits on a 0->1 HWInt transition (previous-value register per line) and keep them sticky until cleared.
REQ-029 SHALL, in edge mode, clear only Pending[IntId] on the IntAck edge; an edge on the same line in that cycle SHALL keep the bit set.
REQ-030 SHALL, when IRQ_CTRL_EDGE_EN is undefined, use level mode as in REQ-022 and remove the edge registers.

Structure
REQ-031 SHALL place the FSM state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2) and the NUM_INT default in shared header cpu_defs.
REQ-032 SHALL implement priority selection in one combinational sub-module, irq_prio_enc (NUM_INT in, valid + ID_W index out).

Verification
REQ-033 SHALL test: IE=1, Mask=6'h3F, HWInt=6'b000100 -> IntReq=1 one cycle later, IntId=2.
REQ-034 SHALL test: HWInt=6'b100001 -> IntId=5; IntAck -> InService=1, IntReq=0; Eret -> IDLE, then IntReq=1 again if lines are still high.
REQ-035 SHALL test: Mask=6'h00, HWInt=6'h3F -> IntReq stays 0; MaskWE with 6'h08 -> IntReq=1, IntId=3.
REQ-036 SHALL test: Reset low during REQ -> all outputs 0 immediately, without waiting for Clk.
REQ-037 SHALL test, with IRQ_CTRL_EDGE_EN defined: a 1-cycle pulse on HWInt[1] -> Pending[1] stays 1 until IntAck, then clears.
REQ-038 SHALL test, with NUM_INT=8 and ID_W=3: HWInt[7] -> IntId=7.
